mips32_lane_ram: RTL
====================

Name: mips32_lane_ram

Overview:
- Next-generation block-RAM wrapper for the MIPS32 standalone system: one write port and one read port, with byte-lane writes, a selectable read latency of 1 or 2 cycles, and a readValid strobe.
- Per-lane write-first forwarding on same-address collisions.
- A hardware zero-fill sequencer that clears the whole array after reset or on request.
- Instruction and data memories use it so boot code never sees uninitialised RAM.

Parameters:
- AWIDTH, 10, address width; depth = 2^AWIDTH words.
- DWIDTH, 32, data width; must equal 8*LANES when LANES > 1.
- LANES, 4, byte lanes; 1 means whole-word writes only.
- OREG, 0, 0 = read latency 1; 1 = extra output register, read latency 2.
- CLEAR, 1, 1 = zero-fill automatically after reset; 0 = zero-fill only on clearReq.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- readAddr  in  AWIDTH  read word address.
- readEnable  in  1  read request, sampled on the clock edge.
- readData  out  DWIDTH  registered read data.
- readValid  out  1  readData holds the result of a read this cycle.
- writeAddr  in  AWIDTH  write word address.
- writeData  in  DWIDTH  write data.
- writeLane  in  LANES  per-byte write enables; used only when LANES > 1.
- writeEnable  in  1  write strobe; must be high for any lane to be written.
- clearReq  in  1  one-cycle request to start a zero-fill.
- busy  out  1  zero-fill in progress; all read and write requests are ignored.

Behaviour:
- Reset values (asynchronous, active-high):
  - readData = 0, readValid = 0, clear counter = 0.
  - FSM = CLEARING if CLEAR = 1, else IDLE; busy follows the FSM.
  - Array contents are not reset directly; only the zero-fill clears them.
- FSM states: IDLE, CLEARING.
  - CLEARING: each cycle writes 0 to address cnt, then cnt increments. When cnt reaches 2^AWIDTH-1, that word is written and the FSM moves to IDLE the next cycle.
  - A full clear takes exactly 2^AWIDTH cycles with busy = 1.
  - IDLE with clearReq = 1: move to CLEARING, cnt = 0, busy = 1 from the next cycle.
  - clearReq while busy is ignored.
  - Reset asserted mid-clear restarts at cnt = 0 (CLEAR = 1) or aborts to IDLE (CLEAR = 0).
- Writes (IDLE only):
  - LANES = 1: writeEnable writes the full word.
  - LANES > 1: byte i is written iff writeEnable && writeLane[i].
  - Writes take effect at the clock edge.
- Reads (IDLE only):
  - OREG = 0: readEnable at edge N gives readData/readValid at edge N+1.
  - OREG = 1: result appears at edge N+2, with readValid delayed identically.
  - readValid is high for exactly one cycle per accepted read.
  - readData holds its last value when no read completes; it is not affected by later writes to the same address.
- Read/write collision, same address, same cycle: read is write-first per lane. Written lanes return writeData; unwritten lanes return prior memory contents.
- A write at edge N followed by a read at edge N+1 returns the new data (ordinary RAM behaviour).
- Requests while busy:
  - readEnable produces no readValid.
  - Writes are dropped.
  - Reads already in the OREG pipeline when busy rises still complete.
- Address arithmetic is unsigned; the clear counter is AWIDTH+1 bits to detect the terminal count without wrap aliasing.
- Storage must map to inferred block RAM: synchronous read only; forwarding and output registers live outside the array.

Decomposition:
- Shared package mips32_mem_pkg: FSM state encoding (IDLE, CLEARING) and a helper function computing depth from AWIDTH.
- One sub-module, mips32_lane_ram_core: the bare array with one synchronous-read port and one byte-lane write port, so synthesis infers block RAM.
- The wrapper holds:
  - the clear FSM and counter;
  - the write mux (the clear writes 0 with all lanes enabled);
  - collision forwarding;
  - the OREG stage and the readValid pipeline.

Test Plan:
- CLEAR = 1, AWIDTH = 4, release reset: busy = 1 for exactly 16 cycles. Then reading addresses 0..15 returns 0x00000000 with readValid one cycle after each readEnable.
- Write 0xDEADBEEF to address 5 with lanes 4'b1111, then a lane write of 0x11223344 with lanes 4'b0101. Reading address 5 returns 0xDE22BE44.
- Same-cycle write of 0xAABBCCDD with lanes 4'b0011 and read of address 7 (old value 0x12345678) returns 0x1234CCDD. A read of address 7 the next cycle returns the same value.
- OREG = 1: reads of addresses 1, 2, 3 issued back-to-back. readValid is high on cycles N+2..N+4 with matching data, and no bubbles.
- clearReq after filling memory: writes and reads during busy are ignored with no readValid. After 16 cycles all words read 0; a second clearReq mid-clear does not restart the count.
- Reset asserted at clear cycle 8: busy stays 1 and a full 16-cycle clear restarts from address 0. readValid = 0 and readData = 0 immediately on reset assertion.

Source files
------------

// File: rtl/mips32_mem_pkg.sv
// Shared types for the MIPS32 memory wrappers: zero-fill FSM encoding and a
// depth helper.
package mips32_mem_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    CLEARING = 1'b1
  } clr_state_t;

  function automatic int unsigned mem_depth(input int unsigned awidth);
    return 32'd1 << awidth;
  endfunction

endpackage

// File: rtl/mips32_lane_ram_core.sv
// Bare storage array: one synchronous read port and one byte-lane write port.
// No reset and no read-side logic, so synthesis can map it onto block RAM.
module mips32_lane_ram_core
  import mips32_mem_pkg::*;
#(
  parameter int AWIDTH = 10,
  parameter int DWIDTH = 32,
  parameter int LANES  = 4
) (
  input  logic              clock,
  input  logic              rd_en,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic [DWIDTH-1:0] rd_data,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic [LANES-1:0]  wr_lane
);

  localparam int LW    = DWIDTH / LANES;
  localparam int DEPTH = int'(mem_depth(AWIDTH));

  logic [DWIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    for (int i = 0; i < LANES; i++) begin
      if (wr_lane[i]) mem[wr_addr][i*LW +: LW] <= wr_data[i*LW +: LW];
    end
  end

  // Read-before-write: a same-edge collision returns the old word here.
  always_ff @(posedge clock) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/mips32_lane_ram.sv
// Block-RAM wrapper with byte-lane writes, write-first collision forwarding,
// optional output register and a hardware zero-fill sequencer.
module mips32_lane_ram
  import mips32_mem_pkg::*;
#(
  parameter int AWIDTH = 10,
  parameter int DWIDTH = 32,
  parameter int LANES  = 4,
  parameter int OREG   = 0,
  parameter int CLEAR  = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [AWIDTH-1:0] readAddr,
  input  logic              readEnable,
  output logic [DWIDTH-1:0] readData,
  output logic              readValid,
  input  logic [AWIDTH-1:0] writeAddr,
  input  logic [DWIDTH-1:0] writeData,
  input  logic [LANES-1:0]  writeLane,
  input  logic              writeEnable,
  input  logic              clearReq,
  output logic              busy
);

  localparam int LW = DWIDTH / LANES;
  localparam logic [AWIDTH:0] LAST = (AWIDTH+1)'(mem_depth(AWIDTH) - 1);

  clr_state_t        state, state_nxt;
  logic [AWIDTH:0]   cnt, cnt_nxt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= (CLEAR != 0) ? CLEARING : IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (clearReq) begin
          state_nxt = CLEARING;
          cnt_nxt   = '0;
        end
      end
      CLEARING: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == CLEARING);

  logic [LANES-1:0]  user_lane;
  logic [LANES-1:0]  core_lane;
  logic [AWIDTH-1:0] core_waddr;
  logic [DWIDTH-1:0] core_wdata;
  logic [DWIDTH-1:0] core_rd;
  logic              rd_go;

  assign user_lane  = (LANES == 1) ? {LANES{writeEnable}}
                                   : (writeLane & {LANES{writeEnable}});
  assign core_lane  = busy ? {LANES{1'b1}} : user_lane;
  assign core_waddr = busy ? cnt[AWIDTH-1:0] : writeAddr;
  assign core_wdata = busy ? '0 : writeData;
  assign rd_go      = readEnable & ~busy;

  mips32_lane_ram_core #(
    .AWIDTH (AWIDTH),
    .DWIDTH (DWIDTH),
    .LANES  (LANES)
  ) u_core (
    .clock   (clock),
    .rd_en   (rd_go),
    .rd_addr (readAddr),
    .rd_data (core_rd),
    .wr_addr (core_waddr),
    .wr_data (core_wdata),
    .wr_lane (core_lane)
  );

  // Collision lanes are captured beside the array and merged after it.
  logic [LANES-1:0]  fwd_lane;
  logic [DWIDTH-1:0] fwd_data;
  logic              valid1;
  logic              data_ok;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fwd_lane <= '0;
      fwd_data <= '0;
      valid1   <= 1'b0;
      data_ok  <= 1'b0;
    end else begin
      valid1 <= rd_go;
      if (rd_go) begin
        data_ok  <= 1'b1;
        fwd_lane <= (writeAddr == readAddr) ? user_lane : '0;
        fwd_data <= writeData;
      end
    end
  end

  logic [DWIDTH-1:0] merged;
  logic [DWIDTH-1:0] s1_data;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign merged[g*LW +: LW] = fwd_lane[g] ? fwd_data[g*LW +: LW]
                                            : core_rd[g*LW +: LW];
  end

  // data_ok masks the unreset array output so readData reads 0 after reset.
  assign s1_data = data_ok ? merged : '0;

  if (OREG != 0) begin : g_oreg
    logic [DWIDTH-1:0] out_q;
    logic              valid2;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        out_q  <= '0;
        valid2 <= 1'b0;
      end else begin
        valid2 <= valid1;
        if (valid1) out_q <= s1_data;
      end
    end

    assign readData  = out_q;
    assign readValid = valid2;
  end else begin : g_direct
    assign readData  = s1_data;
    assign readValid = valid1;
  end

endmodule
